barrier_scheduler: RTL and testbench
====================================

# barrier_scheduler

Sequencer for the barrier lookup in the lane-runner game. It owns the 8-bit pattern index fed to `barrier_data` and samples the returned 3-lane row on every scroll step. Sampled rows go into a ROWS-deep playfield shift register for the display path. The block also runs the game state machine: idle, run, crash. It provides player collision detection, a score counter, and a scroll period that speeds up as the game goes on.

## Interface
Parameters:
- `ROWS`, 8: visible playfield rows; row 0 is the player row, row ROWS-1 is the newest.
- `TICK_INIT`, 16'd50000: clocks per scroll step at game start.
- `TICK_MIN`, 16'd10000: floor for the scroll period.
- `TICK_STEP`, 16'd2000: period decrement applied every 64 steps.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level, sampled each clock; acts only in IDLE or CRASH.
- `player_lane` in 3: player position, one-hot `{left,mid,right}`; 0 means no collision is possible.
- `barrier_in` in 3: row pattern returned combinationally by `barrier_data` for `barrier_cnt`.
- `barrier_cnt` out 8: pattern index to `barrier_data`; reset 0.
- `rows` out 3*ROWS: playfield; row i is `rows[3i+2:3i]`; reset 0.
- `score` out 16: steps survived, saturating; reset 0.
- `step` out 1: one-cycle pulse, high in the cycle the updated `rows` first appear; reset 0.
- `running` out 1: high in RUN; reset 0.
- `crash` out 1: high in CRASH; reset 0.

## Operation
- States: IDLE, RUN, CRASH. Reset forces IDLE with all registers cleared: `barrier_cnt`=0, `rows`=0, `score`=0, divider=0, `period`=TICK_INIT.
- IDLE: with `start`=1, go to RUN. Registers are already clear.
- CRASH: with `start`=1, clear every register as reset does and go directly to RUN. Otherwise all state is frozen and `crash`=1.
- RUN, divider: 16-bit `div_cnt` counts 0..`period`-1.
- RUN, scroll step: taken at an edge where `div_cnt`==`period`-1 and no collision is present. At that edge:
  - `div_cnt` goes to 0.
  - `rows` shifts toward the player: row i takes row i+1, row ROWS-1 takes `barrier_in`, and the old row 0 is discarded.
  - `barrier_cnt` increments modulo 256; it wraps 255 to 0 with no special handling.
  - `score` increments and saturates at 16'hFFFF.
  - `step` is set for one cycle.
- Speed-up: on a step where the new `barrier_cnt[5:0]`==0, `period` becomes max(`period`-TICK_STEP, TICK_MIN). Compute in 17 bits so the subtraction cannot underflow.
- Collision: checked at every edge in RUN. If (`rows[2:0]` & `player_lane`) != 0, go to CRASH.
  - Collision has priority over a step in the same cycle. No shift, no score increment, no `step`.
  - A player moving into an occupied lane of row 0 crashes even between steps.
- Indices 0–9 map to empty rows, so the first 10 rows inserted after a start are clear.
- `start` held high in RUN is ignored. No other input affects state.

## Timing
- `start` sampled at edge E: `running`=1 after E and `div_cnt`=0. The first step occurs at edge E+`period`, and `step` is high for the following cycle.
- A new row enters at row ROWS-1 and reaches row 0 after ROWS-1 further steps.
- Collision latency: an overlap present before edge E gives `crash`=1 and `running`=0 after E.
- `barrier_in` is sampled at the step edge. `barrier_data` is combinational, so 0 extra cycles are required.
- `rst_n`=0 at any edge, including mid-step or in CRASH, returns all outputs to their reset values after that edge.
- The period change takes effect from the next divider cycle.

## Test plan
Bench parameters: ROWS=4, TICK_INIT=4, TICK_MIN=2, TICK_STEP=1.
- Reset, then `start` pulse → `running`=1 after 1 clock. `step` pulses every 4 clocks. `barrier_cnt` goes 1,2,3…. `rows`=0 through the 10th step.
- Run with `player_lane`=0 past `barrier_cnt`=24 → the row inserted at index 24 (3'b110) appears at row 3 and shifts down to row 0 after 3 more steps. No crash.
- `player_lane`=3'b100 while `rows[2:0]`=3'b110 → `crash`=1 on the next edge. `rows`, `score` and `barrier_cnt` freeze. A later `start` clears them and gives `running`=1.
- Collision coincident with `div_cnt`=`period`-1 → CRASH entered, no shift, `score` unchanged, `step`=0.
- Step intervals of 4 clocks for steps 1–64; 3 clocks for steps 65–128; 2 clocks from step 129 onward, never below 2. `barrier_cnt` wraps from 255 to 0.
- `rst_n` low for 1 clock mid-RUN → all outputs at reset values and state IDLE. Preload `score`=16'hFFFE via force, then take 3 steps → `score` saturates at 16'hFFFF.

Source files
------------

// File: rtl/barrier_scheduler.sv
// Purpose : lane-runner sequencer; drives the barrier lookup index, scrolls the
//           playfield, detects player collisions, keeps score and scroll speed.
// Latency : barrier_in sampled at the step edge, new rows and step visible one
//           cycle later; a collision moves to CRASH at the next edge.
// Backpressure: none; start is level-sampled and only acts in IDLE or CRASH.
module barrier_scheduler #(
    parameter int          ROWS      = 8,
    parameter logic [15:0] TICK_INIT = 16'd50000,
    parameter logic [15:0] TICK_MIN  = 16'd10000,
    parameter logic [15:0] TICK_STEP = 16'd2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          player_lane,
    input  logic [2:0]          barrier_in,
    output logic [7:0]          barrier_cnt,
    output logic [3*ROWS-1:0]   rows,
    output logic [15:0]         score,
    output logic                step,
    output logic                running,
    output logic                crash
);

    localparam int RW = 3 * ROWS;

    // Game states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CRASH = 2'd2;

    logic [1:0]    state;
    logic [15:0]   div_cnt;
    logic [15:0]   period;
    logic [7:0]    cnt_q;
    logic [RW-1:0] rows_q;
    logic [15:0]   score_q;
    logic          step_q;

    // Decoded per-cycle events
    logic          in_run;
    logic          collide;
    logic          div_wrap;
    logic          take_step;
    logic          restart;
    logic [7:0]    cnt_next;
    logic [16:0]   period_dec;
    logic [15:0]   period_fast;

    assign in_run   = (state == ST_RUN);

    // Row 0 is the player row; any overlap with the player's lane ends the run,
    // even between scroll steps.
    assign collide  = in_run && ((rows_q[2:0] & player_lane) != 3'b000);

    // Divider reaches the end of the current scroll period.
    assign div_wrap = (div_cnt == (period - 16'd1));

    // Collision wins over a step in the same cycle.
    assign take_step = in_run && !collide && div_wrap;

    // Restart from CRASH clears the whole game, same as reset.
    assign restart  = (state == ST_CRASH) && start;

    assign cnt_next = cnt_q + 8'd1;

    // Speed-up arithmetic in 17 bits so a large step cannot wrap below zero;
    // the result is clamped to the period floor.
    assign period_dec  = {1'b0, period} - {1'b0, TICK_STEP};
    assign period_fast = (period_dec[16] || (period_dec < {1'b0, TICK_MIN}))
                         ? TICK_MIN : period_dec[15:0];

    // Game state machine: IDLE -> RUN on start, RUN -> CRASH on collision,
    // CRASH -> RUN on start (with a full clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        state <= ST_CRASH;
                    end
                end
                ST_CRASH: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Scroll divider: counts 0..period-1 while running; frozen otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
        end else if (restart) begin
            div_cnt <= 16'd0;
        end else if (in_run && !collide) begin
            if (div_wrap) begin
                div_cnt <= 16'd0;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    // Playfield shift: newest row enters at the top, row 0 falls off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_q <= '0;
        end else if (restart) begin
            rows_q <= '0;
        end else if (take_step) begin
            rows_q <= {barrier_in, rows_q[RW-1:3]};
        end
    end

    // Barrier lookup index: free-running modulo 256, one per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (restart) begin
            cnt_q <= 8'd0;
        end else if (take_step) begin
            cnt_q <= cnt_next;
        end
    end

    // Score: one point per survived step, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= 16'd0;
        end else if (restart) begin
            score_q <= 16'd0;
        end else if (take_step && (score_q != 16'hFFFF)) begin
            score_q <= score_q + 16'd1;
        end
    end

    // Scroll period: shortened every 64 steps (when the new index's low six
    // bits are zero), taking effect from the next divider cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period <= TICK_INIT;
        end else if (restart) begin
            period <= TICK_INIT;
        end else if (take_step && (cnt_next[5:0] == 6'd0)) begin
            period <= period_fast;
        end
    end

    // Step strobe: high for the one cycle in which the shifted rows first show.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= take_step;
        end
    end

    assign barrier_cnt = cnt_q;
    assign rows        = rows_q;
    assign score       = score_q;
    assign step        = step_q;
    assign running     = in_run;
    assign crash       = (state == ST_CRASH);

endmodule

// File: tb/tb_barrier_scheduler.sv
// Purpose : self-checking bench for barrier_scheduler with a small geometry.
// Latency : outputs compared 1 time unit after each rising edge.
// Backpressure: none; stimulus is a directed linear sequence.
module tb_barrier_scheduler;

    localparam int ROWS = 4;
    localparam int RW   = 3 * ROWS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    player_lane;
    logic [2:0]    barrier_in;
    logic [7:0]    barrier_cnt;
    logic [RW-1:0] rows;
    logic [15:0]   score;
    logic          step;
    logic          running;
    logic          crash;

    always #5 clk = ~clk;

    barrier_scheduler #(
        .ROWS      (ROWS),
        .TICK_INIT (16'd4),
        .TICK_MIN  (16'd2),
        .TICK_STEP (16'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .player_lane (player_lane),
        .barrier_in  (barrier_in),
        .barrier_cnt (barrier_cnt),
        .rows        (rows),
        .score       (score),
        .step        (step),
        .running     (running),
        .crash       (crash)
    );

    // Stand-in for the barrier ROM: indices 0-9 empty, index 24 is 3'b110.
    function automatic logic [2:0] bdata(input logic [7:0] idx);
        if (idx < 8'd10)          return 3'b000;
        if (idx == 8'd24)         return 3'b110;
        if ((idx % 8'd5) == 8'd0) return 3'b011;
        if ((idx % 8'd7) == 8'd0) return 3'b101;
        return 3'b000;
    endfunction

    assign barrier_in = bdata(barrier_cnt);

    typedef struct packed {
        logic [7:0]    cnt;
        logic [RW-1:0] rws;
        logic [15:0]   scr;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference game model
    int            m_state;
    logic [15:0]   m_div;
    logic [15:0]   m_period;
    logic [7:0]    m_cnt;
    logic [RW-1:0] m_rows;
    logic [15:0]   m_score;
    logic          m_step;
    int            gstep;
    int            last_step_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_div    = 16'd0;
        m_period = 16'd4;
        m_cnt    = 8'd0;
        m_rows   = '0;
        m_score  = 16'd0;
        m_step   = 1'b0;
    endtask

    // Advance model and DUT one clock, then compare; step outputs go via scoreboard.
    task automatic tick();
        logic [2:0] bin;
        exp_t       e;
        int         p;
        int         exp_iv;
        bin    = bdata(m_cnt);
        m_step = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state = 1;
                    m_div = 16'd0;
                    gstep = 0;
                    last_step_cyc = cyc + 1;
                end
                2: if (start) begin
                    model_reset();
                    m_state = 1;
                    gstep = 0;
                    last_step_cyc = cyc + 1;
                end
                default: begin
                    if ((m_rows[2:0] & player_lane) != 3'b000) begin
                        m_state = 2;
                    end else if (m_div == m_period - 16'd1) begin
                        m_div  = 16'd0;
                        m_rows = {bin, m_rows[RW-1:3]};
                        m_cnt  = m_cnt + 8'd1;
                        if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
                        m_step = 1'b1;
                        if (m_cnt[5:0] == 6'd0) begin
                            p = int'(m_period) - 1;
                            if (p < 2) p = 2;
                            m_period = p[15:0];
                        end
                        e.cnt = m_cnt;
                        e.rws = m_rows;
                        e.scr = m_score;
                        sb_q.push_back(e);
                    end else begin
                        m_div = m_div + 16'd1;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("step", step, m_step);
        chk("running", running, (m_state == 1));
        chk("crash", crash, (m_state == 2));
        if (step === 1'b1) begin
            gstep++;
            exp_iv = (gstep <= 64) ? 4 : (gstep <= 128) ? 3 : 2;
            chk("interval", cyc - last_step_cyc, exp_iv);
            last_step_cyc = cyc;
            chk("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_cnt", barrier_cnt, e.cnt);
                chk("sb_rows", rows, e.rws);
                chk("sb_score", score, e.scr);
            end
        end
    endtask

    // Run until n steps have been seen, bounded by a cycle budget.
    task automatic run_steps(input int n, input int budget);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < budget) begin
            tick();
            t++;
            if (step === 1'b1) seen++;
        end
        chk("run_steps_done", seen, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnt"}, barrier_cnt, 0);
        chk({tag, "_rows"}, rows, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_crash"}, crash, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        player_lane = 3'b000;
        gstep = 0;
        last_step_cyc = 0;
        model_reset();
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Start and scroll through the empty opening rows.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_after_start", running, 1);
        run_steps(10, 100);
        chk("rows_clear_10", rows, 0);
        chk("cnt_10", barrier_cnt, 10);

        // Index 24 enters at the top on step 25, reaches row 0 on step 28.
        run_steps(15, 100);
        chk("row3_idx24", rows[RW-1 -: 3], 3'b110);
        run_steps(3, 50);
        chk("row0_idx24", rows[2:0], 3'b110);
        chk("no_crash_lane0", crash, 0);

        // Player steps into the occupied lane between steps.
        tick();
        player_lane = 3'b100;
        tick();
        chk("crash_set", crash, 1);
        chk("crash_not_running", running, 0);
        repeat (6) tick();
        chk("frozen_cnt", barrier_cnt, 28);
        chk("frozen_score", score, 28);
        chk("frozen_row0", rows[2:0], 3'b110);

        // Restart from CRASH clears everything.
        player_lane = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_running", running, 1);
        chk("restart_cnt", barrier_cnt, 0);
        chk("restart_rows", rows, 0);
        chk("restart_score", score, 0);

        // Collision in the same cycle a step is due.
        run_steps(28, 200);
        tick();
        tick();
        tick();
        player_lane = 3'b100;
        tick();
        chk("coinc_crash", crash, 1);
        chk("coinc_step", step, 0);
        chk("coinc_score", score, 28);
        chk("coinc_cnt", barrier_cnt, 28);
        chk("coinc_row0", rows[2:0], 3'b110);

        // Long run: speed-up schedule and index wrap.
        player_lane = 3'b000;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_steps(255, 2000);
        chk("cnt_255", barrier_cnt, 255);
        run_steps(1, 10);
        chk("cnt_wrap", barrier_cnt, 0);
        chk("score_256", score, 256);
        run_steps(20, 100);
        chk("cnt_after_wrap", barrier_cnt, 20);

        // Reset pulse in the middle of a run.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("midrun_reset");
        repeat (5) tick();
        chk("idle_cnt", barrier_cnt, 0);
        chk("idle_running", running, 0);

        // Score saturation from a preloaded value.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        force dut.score_q = 16'hFFFE;
        #1;
        release dut.score_q;
        m_score = 16'hFFFE;
        run_steps(1, 10);
        chk("score_ffff", score, 16'hFFFF);
        run_steps(2, 20);
        chk("score_sat", score, 16'hFFFF);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
